// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the P5 MIPS core: tracks in-flight writes in E/M/W and
// decides D-stage stall and operand forwarding. Optional macro: HAZARD_STALL_CNT_EN.
module hazard_scoreboard #(
    parameter int TW = 4,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] D_A1,
    input  logic [RW-1:0] D_A2,
    input  logic          D_A1use,
    input  logic          D_A2use,
    input  logic [TW-1:0] D_rs_Tuse,
    input  logic [TW-1:0] D_rt_Tuse,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_Reg_Write,
    input  logic [RW-1:0] D_WA,
    output logic          stall,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel,
    output logic [RW-1:0] E_WA,
    output logic [TW-1:0] E_Tnew
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    typedef struct packed {
        logic          wv;
        logic [RW-1:0] wa;
        logic [TW-1:0] tnew;
    } entry_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] sel;
    } op_res_t;

    localparam logic [1:0] SEL_GRF = 2'd0;
    localparam logic [1:0] SEL_E   = 2'd1;
    localparam logic [1:0] SEL_M   = 2'd2;
    localparam logic [1:0] SEL_W   = 2'd3;

    entry_t e_q, m_q, w_q;
    entry_t e_d, m_d, w_d;

    op_res_t rs_res, rt_res;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    // $0 is never live, so a write to it can neither stall nor forward.
    function automatic logic hits(input entry_t ent, input logic [RW-1:0] addr,
                                  input logic rd_en);
        return ent.wv && (ent.wa != '0) && (ent.wa == addr) && rd_en && (addr != '0);
    endfunction

    // Youngest match wins; older matches of the same register are shadowed.
    function automatic op_res_t resolve(input entry_t ent_e, input entry_t ent_m,
                                        input entry_t ent_w, input logic [RW-1:0] addr,
                                        input logic rd_en, input logic [TW-1:0] tuse);
        op_res_t r;
        r.stall = 1'b0;
        r.sel   = SEL_GRF;
        if (hits(ent_e, addr, rd_en)) begin
            r.stall = (ent_e.tnew > tuse);
            r.sel   = (ent_e.tnew == '0) ? SEL_E : SEL_GRF;
        end else if (hits(ent_m, addr, rd_en)) begin
            r.stall = (ent_m.tnew > tuse);
            r.sel   = (ent_m.tnew == '0) ? SEL_M : SEL_GRF;
        end else if (hits(ent_w, addr, rd_en)) begin
            r.sel   = (ent_w.tnew == '0) ? SEL_W : SEL_GRF;
        end
        return r;
    endfunction

    always_comb begin
        rs_res = resolve(e_q, m_q, w_q, D_A1, D_A1use, D_rs_Tuse);
        rt_res = resolve(e_q, m_q, w_q, D_A2, D_A2use, D_rt_Tuse);
    end

    assign stall      = rs_res.stall | rt_res.stall;
    assign fwd_rs_sel = rs_res.sel;
    assign fwd_rt_sel = rt_res.sel;
    assign E_WA       = e_q.wa;
    assign E_Tnew     = e_q.tnew;

    always_comb begin
        w_d.wv   = m_q.wv;
        w_d.wa   = m_q.wa;
        w_d.tnew = dec_sat(m_q.tnew);
        m_d.wv   = e_q.wv;
        m_d.wa   = e_q.wa;
        m_d.tnew = dec_sat(e_q.tnew);
        e_d      = '0;
        if (!stall) begin
            e_d.wv   = D_Reg_Write;
            e_d.wa   = D_WA;
            e_d.tnew = dec_sat(D_Tnew);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d     = stall ? cnt_q + 32'd1 : cnt_q;
    assign stall_cnt = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer side of the D-stage decode outputs (A1/A2 use flags, rs/rt Tuse, Tnew, write-enable, destination register).
- Tracks every in-flight register write through the E, M and W pipeline stages in a 3-entry shift pipeline, counting Tnew down each cycle.
- From that state it produces the D-stage stall/bubble decision and per-operand forwarding source selects for the P5 pipelined MIPS core.

Parameters:
- TW, 4, width of Tuse/Tnew fields.
- RW, 5, register-address width.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all entries.
- D_A1  input  RW  rs address of the instruction in D.
- D_A2  input  RW  rt address of the instruction in D.
- D_A1use  input  1  D instruction reads rs.
- D_A2use  input  1  D instruction reads rt.
- D_rs_Tuse  input  TW  cycles until rs is needed, counted from D.
- D_rt_Tuse  input  TW  cycles until rt is needed, counted from D.
- D_Tnew  input  TW  cycles until the result exists, counted from D.
- D_Reg_Write  input  1  D instruction writes the register file.
- D_WA  input  RW  resolved destination register (rd, rt or 31).
- stall  output  1  hold PC and the F/D register; inject a bubble into E.
- fwd_rs_sel  output  2  rs source: 0 = GRF, 1 = E, 2 = M, 3 = W.
- fwd_rt_sel  output  2  rt source, same encoding.
- E_WA  output  RW  destination held in the E entry (debug/observation).
- E_Tnew  output  TW  Tnew held in the E entry.

Behaviour:
- Entry format: {wv, wa, tnew}. Entries E, M, W.
- An entry is "live" when wv = 1 and wa != 0. Register $0 is never live, never stalls and never forwards.
- Async reset: every entry becomes {0, 0, 0}.
  - Outputs after reset: stall = 0, fwd_rs_sel = 0, fwd_rt_sel = 0, E_WA = 0, E_Tnew = 0.
- Each rising edge when not in reset:
  - W <= {M.wv, M.wa, dec(M.tnew)}
  - M <= {E.wv, E.wa, dec(E.tnew)}
  - E <= stall ? {0, 0, 0} : {D_Reg_Write, D_WA, dec(D_Tnew)}
  - dec(x) is a saturating decrement: dec(x) = (x == 0) ? 0 : x - 1. It never wraps.
- Match for an operand (rs shown; rt is identical using D_A2, D_A2use, D_rt_Tuse):
  - A stage matches when it is live, its wa == D_A1, D_A1use = 1 and D_A1 != 0.
  - Priority is youngest first: E, then M, then W. Only the youngest matching stage counts; older matches are shadowed.
- stall_rs = 1 when the youngest match is E or M and its tnew > D_rs_Tuse.
  - W tnew is always 0 by construction, so W never causes a stall.
- stall = stall_rs | stall_rt. Purely combinational, same cycle.
- fwd_rs_sel:
  - Youngest match with tnew == 0: 1 for E, 2 for M, 3 for W.
  - Otherwise 0, which covers no match and a pending stall.
  - A stage whose tnew is still nonzero but <= Tuse gives sel 0 this cycle; the value is forwarded at a later stage.
- Stall repeats each cycle until the producer's tnew falls to <= Tuse. D inputs are held externally, so re-evaluation is automatic.
- Simultaneous events:
  - Stall and shift occur on the same edge. The bubble enters E while the old E moves to M.
  - D_Reg_Write with D_WA = 0 enters as a non-live entry.
- Reset asserted mid-stall: all entries clear immediately and stall drops the same cycle.
- E_WA and E_Tnew are direct copies of the E entry fields.

Optional Feature:
- HAZARD_STALL_CNT_EN
- When defined:
  - Adds output stall_cnt[31:0]. It increments on every rising edge where stall = 1 and reset = 0, and wraps from 0xFFFFFFFF to 0.
  - Async reset clears it to 0.
- When undefined: the port and counter are absent; all other behaviour is unchanged.

Test Plan:
- lw $8 (Tnew 3, WA 8), then addu using rs = $8 (rs_Tuse 1):
  - Cycle with lw in E: E tnew = 2 > 1, so stall = 1.
  - Next cycle: lw in M with tnew 1 <= 1, so stall = 0 and fwd_rs_sel = 0.
  - Following cycle: lw in W with tnew 0; the addu, now in E, is out of scope, and the bench checks the E entry equals {1, dst, 1}.
- ori $9 (Tnew 2), then beq $9,$9 (rs/rt Tuse 0):
  - Stall 1 cycle.
  - Then rs = rt = M with tnew 0, so fwd_rs_sel = fwd_rt_sel = 2.
- jal (Tnew 1, WA 31), then jr $31 (Tuse 0): jal enters E with tnew 0, so stall = 0 and fwd_rs_sel = 1.
- Shadowing: E {1, 5, 1} and M {1, 5, 0} with D rs = $5, Tuse 1 -> stall = 0, fwd_rs_sel = 0. M is ignored because E is younger.
- $0 writer: lw $0 then addu reading $0 -> stall = 0, fwd = 0 in every cycle.
- Assert reset while stall = 1 -> stall, both sels and E_WA read 0 immediately; stall_cnt = 0 when HAZARD_STALL_CNT_EN is defined.
